// File: rtl/mem_arbiter_if.sv
// Request/memory bus bundle for mem_arbiter: fetch port, data port and memory side.
// The slave modport is the arbiter's view; master is the requester/memory environment.
interface mem_arbiter_if;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ready;
    logic          if_done;
    logic [DW-1:0] if_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ready;
    logic          d_done;
    logic [DW-1:0] d_rdata;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    logic          err;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        output if_ready, if_done, if_rdata, d_ready, d_done, d_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, err
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        input  if_ready, if_done, if_rdata, d_ready, d_done, d_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto a single request/ack memory port,
// with fetch anti-starvation and a memory-ack timeout that aborts with an err pulse.
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic {S_IDLE, S_WAIT} state_e;
    typedef enum logic {OWN_DATA, OWN_FETCH} owner_e;

    state_e        state_q,      state_d;
    owner_e        owner_q,      owner_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic [TW-1:0] timer_q,      timer_d;
    logic          mem_req_q,    mem_req_d;
    logic          mem_we_q,     mem_we_d;
    logic [AW-1:0] mem_addr_q,   mem_addr_d;
    logic [DW-1:0] mem_wdata_q,  mem_wdata_d;
    logic          if_done_q,    if_done_d;
    logic          d_done_q,     d_done_d;
    logic          err_q,        err_d;
    logic [DW-1:0] if_rdata_q,   if_rdata_d;
    logic [DW-1:0] d_rdata_q,    d_rdata_d;

    logic starved_c;
    logic grant_fetch_c;
    logic grant_data_c;

    // Grant decision: only in IDLE, forced to fetch once data has won STARVE_MAX times in a row.
    always_comb begin
        starved_c     = (starve_cnt_q == SW'(STARVE_MAX));
        grant_fetch_c = 1'b0;
        grant_data_c  = 1'b0;
        if (!rst && state_q == S_IDLE) begin
            if (bus.if_req && (starved_c || !bus.d_req)) begin
                grant_fetch_c = 1'b1;
            end else if (bus.d_req) begin
                grant_data_c = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        starve_cnt_d = starve_cnt_q;
        timer_d      = timer_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_done_d    = 1'b0;
        d_done_d     = 1'b0;
        err_d        = 1'b0;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;

        // Starvation counter tracks data wins only while a fetch is actually waiting.
        if (!bus.if_req || grant_fetch_c) begin
            starve_cnt_d = '0;
        end else if (grant_data_c && !starved_c) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (grant_fetch_c) begin
                    state_d     = S_WAIT;
                    owner_d     = OWN_FETCH;
                    timer_d     = TW'(1);
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.if_addr;
                    mem_wdata_d = '0;
                end else if (grant_data_c) begin
                    state_d     = S_WAIT;
                    owner_d     = OWN_DATA;
                    timer_d     = TW'(1);
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.d_we;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                end
            end
            S_WAIT: begin
                // An ack on the final timer cycle still counts as a normal completion.
                if (mem_req_q && bus.mem_ack) begin
                    state_d   = S_IDLE;
                    timer_d   = '0;
                    mem_req_d = 1'b0;
                    if (owner_q == OWN_FETCH) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = bus.mem_rdata;
                    end else begin
                        d_done_d = 1'b1;
                        if (!mem_we_q) begin
                            d_rdata_d = bus.mem_rdata;
                        end
                    end
                end else if (timer_q == TW'(TIMEOUT)) begin
                    state_d   = S_IDLE;
                    timer_d   = '0;
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    if (owner_q == OWN_FETCH) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = '0;
                    end else begin
                        d_done_d  = 1'b1;
                        d_rdata_d = '0;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_DATA;
            starve_cnt_q <= '0;
            timer_q      <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_done_q    <= 1'b0;
            d_done_q     <= 1'b0;
            err_q        <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
            timer_q      <= timer_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_done_q    <= if_done_d;
            d_done_q     <= d_done_d;
            err_q        <= err_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign bus.if_ready  = grant_fetch_c;
    assign bus.d_ready   = grant_data_c;
    assign bus.if_done   = if_done_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_done    = d_done_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.err       = err_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: max consecutive data grants while a fetch is pending.
REQ-002 Parameter TIMEOUT, default 15: max cycles waiting for mem_ack before abort.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 if_req  in  1  fetch request, held until if_ready.
REQ-006 if_addr  in  32  fetch address.
REQ-007 if_ready  out  1  fetch accepted this cycle (combinational).
REQ-008 if_done  out  1  one-cycle fetch completion pulse.
REQ-009 if_rdata  out  32  fetched word, valid with if_done.
REQ-010 d_req  in  1  data request (load or store), held until d_ready.
REQ-011 d_we  in  1  1 = store, 0 = load.
REQ-012 d_addr  in  32  data address.
REQ-013 d_wdata  in  32  store data.
REQ-014 d_ready  out  1  data request accepted this cycle (combinational).
REQ-015 d_done  out  1  one-cycle data completion pulse (load and store).
REQ-016 d_rdata  out  32  load data, valid with d_done for loads.
REQ-017 mem_req  out  1  registered memory request, held until ack or abort.
REQ-018 mem_we  out  1  registered write enable.
REQ-019 mem_addr  out  32  registered address.
REQ-020 mem_wdata  out  32  registered write data.
REQ-021 mem_ack  in  1  memory completion; read data valid same cycle.
REQ-022 mem_rdata  in  32  memory read data.
REQ-023 err  out  1  one-cycle pulse on timeout abort.

Function
REQ-024 FSM states: IDLE, WAIT; acceptance occurs only in IDLE.
REQ-025 IDLE grant: if_req && starve_cnt==STARVE_MAX -> fetch; else d_req -> data; else if_req -> fetch; else none.
REQ-026 At most one of if_ready/d_ready high per cycle; neither high outside IDLE or during rst.
REQ-027 On grant: latch addr/we/wdata (fetch: we=0, wdata=0) into mem_* registers, record owner, set mem_req=1 next cycle, enter WAIT.
REQ-028 starve_cnt: +1 on data grant while if_req=1 (saturate at STARVE_MAX); clears on fetch grant or any cycle with if_req=0.
REQ-029 WAIT: mem_ack sampled only while mem_req=1; ack ends transaction, next cycle mem_req=0, state IDLE, owner's done pulses.
REQ-030 Load/fetch completion: owner's rdata register loads mem_rdata on the ack cycle, holds until next read completion.
REQ-031 Store completion: d_done pulses, d_rdata unchanged.
REQ-032 Timer counts WAIT cycles from 1; when it reaches TIMEOUT with no ack: mem_req=0, err and owner's done pulse next cycle, owner's rdata=0, state IDLE.
REQ-033 Ack in the same cycle as timer reaching TIMEOUT: ack wins, no err.
REQ-034 mem_ack while mem_req=0 ignored.
REQ-035 Done-pulse cycle is IDLE; a new grant may occur in that cycle, giving 2-cycle throughput with zero-wait memory.
REQ-036 Request inputs not sampled outside grant cycle; deasserting a request before ready is legal and drops it.

Reset
REQ-037 rst=1: state IDLE, starve_cnt=0, timer=0, owner=data, all outputs 0 (including rdata registers) on next edge.
REQ-038 rst mid-WAIT abandons transaction: mem_req=0 next cycle, no done, no err; any later mem_ack ignored.

Verification
REQ-039 Load: d_req, d_we=0, d_addr=0x100; mem_ack one cycle after mem_req with mem_rdata=0xDEADBEEF -> d_ready cycle 0, mem_req cycles 1-2 with ack at cycle 2 -> d_done cycle 3, d_rdata=0xDEADBEEF.
REQ-040 Simultaneous if_req and d_req, ack immediate -> data granted first, fetch granted on the done cycle; if_done later with fetched word.
REQ-041 Starvation: d_req and if_req held high continuously -> exactly 4 data grants, then 1 fetch grant, pattern repeats.
REQ-042 Timeout: store, mem_ack never asserted -> mem_req high exactly 15 cycles, then err=1 and d_done=1 for one cycle, FSM back in IDLE.
REQ-043 Ack at 15th WAIT cycle -> normal completion, err stays 0.
REQ-044 rst asserted during WAIT, then mem_ack -> no d_done/if_done/err, all outputs 0, next request served normally.
